// File: rtl/pipe_pkg.sv
// Shared defaults and the entry record used by the pipeline stage buffer.
package pipe_pkg;

    localparam int unsigned PC_W_DEF    = 64;
    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 16;

    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    // Storage is sized to the default widths; narrower instances zero-extend on load.
    typedef struct packed {
        logic                   valid;
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry (main + skid) pipeline stage buffer with stall, flush and statistics counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned        PC_W      = PC_W_DEF,
    parameter int unsigned        INSTR_W   = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter int unsigned        CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,

    input  logic               stall,
    input  logic               flush,

    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic accept;
    logic xfer;
    logic reload;

    // in_ready comes straight from the skid valid flop, so out_ready never reaches it.
    assign in_ready = ~skid_q.valid;
    assign accept   = in_valid & in_ready;
    assign xfer     = main_q.valid & out_ready & ~stall;
    assign reload   = xfer | ~main_q.valid;

    always_comb begin
        in_entry       = '0;
        in_entry.valid = 1'b1;
        in_entry.pc    = PC_W_DEF'(in_pc);
        in_entry.instr = INSTR_W_DEF'(in_instr);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
        end else if (reload) begin
            if (skid_q.valid) begin
                main_q       <= skid_q;
                skid_q.valid <= accept;
                if (accept) begin
                    skid_q.pc    <= in_entry.pc;
                    skid_q.instr <= in_entry.instr;
                end
            end else if (accept) begin
                main_q <= in_entry;
            end else begin
                main_q.valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= in_entry;
        end
    end

    assign out_valid = main_q.valid;
    assign out_pc    = main_q.valid ? main_q.pc[PC_W-1:0]       : '0;
    assign out_instr = main_q.valid ? main_q.instr[INSTR_W-1:0] : NOP_INSTR;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall & main_q.valid),
        .clear   (1'b0),
        .count   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush & (main_q.valid | skid_q.valid)),
        .clear   (1'b0),
        .count   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, backpressure, flush, reset and saturation.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready, stall, flush;
    logic [63:0] in_pc, out_pc;
    logic [31:0] in_instr, out_instr;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_reset_n, s_in_valid, s_in_ready, s_out_valid, s_stall;
    logic [63:0] s_out_pc;
    logic [31:0] s_out_instr;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .stall(stall), .flush(flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_buf #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(s_reset_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_pc(64'h7000), .in_instr(32'h7777),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_pc(s_out_pc), .out_instr(s_out_instr),
        .stall(s_stall), .flush(1'b0), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; s_reset_n = 1'b0; s_in_valid = 1'b0; s_stall = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
        in_pc = 64'hdead; in_instr = 32'hbeef;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); errors++; end
        checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", in_ready); errors++; end
        checks++; if (out_pc !== 64'h0) begin $display("FAIL reset_out_pc got %h want 0", out_pc); errors++; end
        checks++; if (out_instr !== 32'h0000_0013) begin $display("FAIL reset_out_instr got %h want 00000013", out_instr); errors++; end
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin $display("FAIL reset_cnts got %0d/%0d want 0/0", stall_cnt, flush_cnt); errors++; end
        @(negedge clk);
        reset_n = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_stream();
        logic [63:0] pcs [3];
        pcs[0] = 64'h1000; pcs[1] = 64'h1004; pcs[2] = 64'h1008;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pc = pcs[i]; in_instr = 32'ha000_0000 + 32'(i);
            checks++; if (in_ready !== 1'b1) begin $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready); errors++; end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== 32'ha000_0000 + 32'(i)) begin
                $display("FAIL stream_out[%0d] got v=%b pc=%h ins=%h want v=1 pc=%h ins=%h",
                         i, out_valid, out_pc, out_instr, pcs[i], 32'ha000_0000 + 32'(i));
                errors++;
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h13 || out_pc !== 64'h0) begin
            $display("FAIL stream_drain got v=%b pc=%h ins=%h want v=0 pc=0 ins=00000013", out_valid, out_pc, out_instr); errors++; end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; in_pc = 64'h2000; in_instr = 32'hb000;
        step();
        stall = 1'b1; in_pc = 64'h2004; in_instr = 32'hb004;
        step();
        checks++; if (in_ready !== 1'b0) begin $display("FAIL bp_in_ready got %b want 0", in_ready); errors++; end
        in_pc = 64'h2008; in_instr = 32'hb008;
        step(); step();
        checks++; if (out_pc !== 64'h2000 || out_instr !== 32'hb000) begin
            $display("FAIL bp_hold got pc=%h ins=%h want pc=2000 ins=0000b000", out_pc, out_instr); errors++; end
        checks++; if (stall_cnt !== 16'd3) begin $display("FAIL bp_stall_cnt got %0d want 3", stall_cnt); errors++; end
        stall = 1'b0;
        step();
        checks++; if (out_pc !== 64'h2004 || in_ready !== 1'b1) begin
            $display("FAIL bp_release1 got pc=%h rdy=%b want pc=2004 rdy=1", out_pc, in_ready); errors++; end
        step();
        checks++; if (out_pc !== 64'h2008 || out_instr !== 32'hb008) begin
            $display("FAIL bp_release2 got pc=%h ins=%h want pc=2008 ins=0000b008", out_pc, out_instr); errors++; end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_drain got %b want 0", out_valid); errors++; end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_pc = 64'h3000; in_instr = 32'hc000;
        step();
        stall = 1'b1; in_pc = 64'h3004;
        step();
        stall = 1'b0; flush = 1'b1; in_pc = 64'h3008;
        step();
        checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0000_0013 || out_pc !== 64'h0) begin
            $display("FAIL flush_out got v=%b pc=%h ins=%h want v=0 pc=0 ins=00000013", out_valid, out_pc, out_instr); errors++; end
        checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd4) begin
            $display("FAIL flush_cnts got f=%0d s=%0d want f=1 s=4", flush_cnt, stall_cnt); errors++; end
        checks++; if (in_ready !== 1'b1) begin $display("FAIL flush_in_ready got %b want 1", in_ready); errors++; end
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL flush_discard1 got %b want 0", out_valid); errors++; end
        // input accepted in the flush cycle must also vanish
        in_valid = 1'b1; in_pc = 64'h3100;
        step();
        flush = 1'b1; in_pc = 64'h3104;
        step();
        flush = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || flush_cnt !== 16'd2) begin
            $display("FAIL flush_discard2 got v=%b f=%0d want v=0 f=2", out_valid, flush_cnt); errors++; end
    endtask

    task automatic test_flush_stall();
        in_valid = 1'b1; in_pc = 64'h4000; in_instr = 32'hd000;
        step();
        in_valid = 1'b0; stall = 1'b1; flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd5 || flush_cnt !== 16'd3) begin
            $display("FAIL flush_stall got v=%b s=%0d f=%0d want v=0 s=5 f=3", out_valid, stall_cnt, flush_cnt); errors++; end
        stall = 1'b0;
        step();
        checks++; if (flush_cnt !== 16'd3) begin $display("FAIL flush_empty got %0d want 3", flush_cnt); errors++; end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_pc = 64'h5000; in_instr = 32'he000;
        step();
        stall = 1'b1; in_pc = 64'h5004;
        step();
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL rstmid_full got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); errors++; end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 64'h0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            $display("FAIL rstmid_async got v=%b rdy=%b pc=%h s=%0d f=%0d want v=0 rdy=1 pc=0 s=0 f=0",
                     out_valid, in_ready, out_pc, stall_cnt, flush_cnt); errors++; end
        flush = 1'b1;
        step(); step();
        checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            $display("FAIL rstmid_ignore got v=%b s=%0d f=%0d want v=0 s=0 f=0", out_valid, stall_cnt, flush_cnt); errors++; end
        @(negedge clk);
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0; in_pc = 64'h6000; in_instr = 32'hf000;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'h6000) begin
            $display("FAIL rstmid_first got v=%b pc=%h want v=1 pc=6000", out_valid, out_pc); errors++; end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_saturate();
        int exp;
        @(negedge clk);
        s_reset_n = 1'b1; s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0; s_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            exp = (i + 1 > 15) ? 15 : i + 1;
            checks++; if (s_stall_cnt !== 4'(exp)) begin
                $display("FAIL sat_stall_cnt[%0d] got %0d want %0d", i, s_stall_cnt, exp); errors++; end
        end
        checks++; if (s_out_valid !== 1'b1 || s_out_pc !== 64'h7000 || s_flush_cnt !== 4'd0) begin
            $display("FAIL sat_hold got v=%b pc=%h f=%0d want v=1 pc=7000 f=0", s_out_valid, s_out_pc, s_flush_cnt); errors++; end
        s_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_stall();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
